// File: rtl/reg17_serializer.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word on Start and shifts it
// out one bit per accepted Bit_Valid/Tx_Ready beat, then pulses Done for one cycle.
module reg17_serializer #(
  parameter int WIDTH     = 17,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [WIDTH-1:0]         D,
  input  logic                     Tx_Ready,
  output logic                     Serial_Out,
  output logic                     Bit_Valid,
  output logic [$clog2(WIDTH)-1:0] Bit_Index,
  output logic                     Busy,
  output logic                     Done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [IW-1:0]    bit_idx, bit_idx_nxt;
  logic             out_bit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE: begin
        if (Start) begin
          shreg_nxt   = D;
          bit_idx_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Without Tx_Ready everything holds, so a stall can last indefinitely.
        if (Tx_Ready) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            shreg_nxt   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        bit_idx_nxt = '0;
      end
      default: begin
        state_nxt   = IDLE;
        bit_idx_nxt = '0;
      end
    endcase
  end

  // Outputs decode only from registered state, so reset clears them immediately.
  assign out_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign Serial_Out = (state == SHIFT) & out_bit;
  assign Bit_Valid  = (state == SHIFT);
  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE);
  assign Bit_Index  = bit_idx;

endmodule

// File: tb/tb_reg17_serializer.sv
// Scoreboard bench for reg17_serializer: one LSB-first and one MSB-first instance
// share inputs; expected bits are queued at Start and popped on each accepted beat.
module tb_reg17_serializer;
  localparam int W = 17;

  logic         Clk = 1'b0;
  logic         Reset, Start, Tx_Ready;
  logic [W-1:0] D;
  logic         so0, bv0, by0, dn0, so1, bv1, by1, dn1;
  logic [4:0]   bi0, bi1;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];
  bit obs_bit[$];
  int obs_idx[$];
  int done_k, busy_cyc;

  reg17_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk(Clk), .Reset(Reset), .Start(Start), .D(D), .Tx_Ready(Tx_Ready),
    .Serial_Out(so0), .Bit_Valid(bv0), .Bit_Index(bi0), .Busy(by0), .Done(dn0));

  reg17_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk(Clk), .Reset(Reset), .Start(Start), .D(D), .Tx_Ready(Tx_Ready),
    .Serial_Out(so1), .Bit_Valid(bv1), .Bit_Index(bi1), .Busy(by1), .Done(dn1));

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit msb);
    for (int i = 0; i < W; i++) exp_q.push_back(msb ? d[W-1-i] : d[i]);
  endtask

  // Pulse Start for one edge (E0); returns just after E0.
  task automatic launch(input logic [W-1:0] d);
    D     = d;
    Start = 1'b1;
    step();
    Start = 1'b0;
    D     = W'($urandom);
  endtask

  // Records accepted beats until Done is seen; returns just after the DONE->IDLE edge.
  task automatic drain(input bit msb);
    logic so, bv, bz, dn;
    logic [4:0] bi;
    done_k   = -1;
    busy_cyc = 0;
    for (int k = 0; k < 200; k++) begin
      so = msb ? so1 : so0;  bv = msb ? bv1 : bv0;  bi = msb ? bi1 : bi0;
      bz = msb ? by1 : by0;  dn = msb ? dn1 : dn0;
      if (bz) busy_cyc++;
      if (bv && Tx_Ready) begin
        obs_bit.push_back(so);
        obs_idx.push_back(int'(bi));
      end
      if (dn && done_k < 0) done_k = k;
      step();
      if (done_k >= 0) break;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({so0, bv0, bi0, by0, dn0, so1, bv1, bi1, by1, dn1} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_initial: outputs=%h required 0",
               {so0, bv0, bi0, by0, dn0, so1, bv1, bi1, by1, dn1});
    end
    Reset = 1'b0;
    Tx_Ready = 1'b1;
    launch(W'($urandom));
    step();
    step();
    #2;
    Reset    = 1'b1;
    Start    = 1'($urandom);
    Tx_Ready = 1'($urandom);
    D        = W'($urandom);
    #1;
    vectors++;
    if ({so0, bv0, bi0, by0, dn0, so1, bv1, bi1, by1, dn1} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_async: outputs=%h required 0",
               {so0, bv0, bi0, by0, dn0, so1, bv1, bi1, by1, dn1});
    end
    step();
    Reset = 1'b0;  Start = 1'b0;  Tx_Ready = 1'b1;
    step();
  endtask

  task automatic test_lsb_first();
    exp_q.delete(); obs_bit.delete(); obs_idx.delete();
    push_word(17'h12345, 1'b0);
    launch(17'h12345);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (obs_bit.size() == 0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL lsb_beat%0d: missing beat, got %0d beats required %0d", i, i, W);
        break;
      end
      if (obs_bit[0] !== exp_q[0] || obs_idx[0] != i) begin
        miscompares++;
        $display("FAIL lsb_beat%0d: bit=%0b idx=%0d required bit=%0b idx=%0d",
                 i, obs_bit[0], obs_idx[0], exp_q[0], i);
      end
      void'(obs_bit.pop_front()); void'(obs_idx.pop_front()); void'(exp_q.pop_front());
    end
    vectors++;
    if (done_k != W || obs_bit.size() != 0) begin
      miscompares++;
      $display("FAIL lsb_done: done at E0+%0d extra_beats=%0d required E0+%0d and 0",
               done_k, obs_bit.size(), W);
    end
    vectors++;
    if (by0 !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_idle: Busy=%0b required 0", by0);
    end
  endtask

  task automatic test_msb_first();
    exp_q.delete(); obs_bit.delete(); obs_idx.delete();
    push_word(17'h10001, 1'b1);
    launch(17'h10001);
    drain(1'b1);
    vectors++;
    if (obs_bit.size() != W) begin
      miscompares++;
      $display("FAIL msb_count: beats=%0d required %0d", obs_bit.size(), W);
    end
    for (int i = 0; i < W && obs_bit.size() > 0 && exp_q.size() > 0; i++) begin
      vectors++;
      if (obs_bit[0] !== exp_q[0] || obs_idx[0] != i) begin
        miscompares++;
        $display("FAIL msb_beat%0d: bit=%0b idx=%0d required bit=%0b idx=%0d",
                 i, obs_bit[0], obs_idx[0], exp_q[0], i);
      end
      void'(obs_bit.pop_front()); void'(obs_idx.pop_front()); void'(exp_q.pop_front());
    end
    vectors++;
    if (busy_cyc != W + 1 || done_k != W || by1 !== 1'b0) begin
      miscompares++;
      $display("FAIL msb_busy: busy_cycles=%0d done=E0+%0d Busy_now=%0b required %0d, E0+%0d, 0",
               busy_cyc, done_k, by1, W + 1, W);
    end
  endtask

  task automatic test_backpressure();
    int s3, s16, beats;
    s3 = 0; s16 = 0; beats = 0; done_k = -1;
    exp_q.delete();
    push_word(17'h1FFFF, 1'b0);
    launch(17'h1FFFF);
    for (int k = 0; k < 200; k++) begin
      Tx_Ready = 1'b1;
      if (bv0 && bi0 == 5'd3 && s3 < 4)   begin Tx_Ready = 1'b0; s3++;  end
      if (bv0 && bi0 == 5'd16 && s16 < 4) begin Tx_Ready = 1'b0; s16++; end
      if (bv0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: beat %0d with empty scoreboard", beats);
        end else if (so0 !== exp_q[0] || bi0 != 5'(beats)) begin
          miscompares++;
          $display("FAIL bp_%s%0d: bit=%0b idx=%0d required bit=%0b idx=%0d",
                   Tx_Ready ? "beat" : "stall", beats, so0, bi0, exp_q[0], beats);
        end
        if (Tx_Ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
      if (dn0) begin
        done_k = k;
        step();
        break;
      end
      step();
    end
    Tx_Ready = 1'b1;
    vectors++;
    if (done_k != W + 8 || beats != W || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_done: done=E0+%0d beats=%0d left=%0d required E0+%0d %0d 0",
               done_k, beats, exp_q.size(), W + 8, W);
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] nxt;
    nxt = 17'h1E0F1;
    exp_q.delete(); obs_bit.delete(); obs_idx.delete();
    push_word(17'h0AAAA, 1'b0);
    launch(17'h0AAAA);
    done_k = -1;
    for (int k = 0; k < 200; k++) begin
      if (k == 5) begin Start = 1'b1; D = '0; end
      if (bv0) obs_bit.push_back(so0);
      if (dn0) begin done_k = k; D = nxt; step(); break; end
      step();
    end
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (obs_bit.size() == 0 || obs_bit[0] !== exp_q[0]) begin
        miscompares++;
        $display("FAIL ignore_beat%0d: got %0d beats, bit=%0b required %0b",
                 i, obs_bit.size(), obs_bit.size() ? obs_bit[0] : 1'b0, exp_q[0]);
        break;
      end
      void'(obs_bit.pop_front()); void'(exp_q.pop_front());
    end
    vectors++;
    if (done_k != W || by0 !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_idle: done=E0+%0d Busy=%0b required E0+%0d 0", done_k, by0, W);
    end
    step();
    Start = 1'b0;
    D     = '0;
    vectors++;
    if (bv0 !== 1'b1 || bi0 !== 5'd0) begin
      miscompares++;
      $display("FAIL ignore_restart: Bit_Valid=%0b idx=%0d required 1 0", bv0, bi0);
    end
    exp_q.delete(); obs_bit.delete(); obs_idx.delete();
    push_word(nxt, 1'b0);
    drain(1'b0);
    for (int i = 0; i < W && obs_bit.size() > 0 && exp_q.size() > 0; i++) begin
      vectors++;
      if (obs_bit[0] !== exp_q[0] || obs_idx[0] != i) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: bit=%0b idx=%0d required bit=%0b idx=%0d",
                 i, obs_bit[0], obs_idx[0], exp_q[0], i);
      end
      void'(obs_bit.pop_front()); void'(obs_idx.pop_front()); void'(exp_q.pop_front());
    end
    vectors++;
    if (exp_q.size() != 0 || done_k != W) begin
      miscompares++;
      $display("FAIL b2b_done: left=%0d done=E0+%0d required 0 E0+%0d", exp_q.size(), done_k, W);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    launch(17'h15555);
    for (int k = 0; k < 5; k++) step();
    vectors++;
    if (bi0 !== 5'd5 || bv0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_pre: idx=%0d valid=%0b required 5 1", bi0, bv0);
    end
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if ({so0, bv0, bi0, by0, dn0} !== 9'd0) begin
      miscompares++;
      $display("FAIL rmid_async: outputs=%h required 0", {so0, bv0, bi0, by0, dn0});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (dn0 || dn1) done_seen++;
    end
    Reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (dn0 || dn1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL rmid_nodone: Done seen %0d cycles required 0", done_seen);
    end
    exp_q.delete(); obs_bit.delete(); obs_idx.delete();
    push_word(17'h00001, 1'b0);
    launch(17'h00001);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (obs_bit.size() == 0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rmid_beat%0d: missing beat", i);
        break;
      end
      if (obs_bit[0] !== exp_q[0] || obs_idx[0] != i) begin
        miscompares++;
        $display("FAIL rmid_beat%0d: bit=%0b idx=%0d required bit=%0b idx=%0d",
                 i, obs_bit[0], obs_idx[0], exp_q[0], i);
      end
      void'(obs_bit.pop_front()); void'(obs_idx.pop_front()); void'(exp_q.pop_front());
    end
    vectors++;
    if (done_k != W) begin
      miscompares++;
      $display("FAIL rmid_done: done=E0+%0d required E0+%0d", done_k, W);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Tx_Ready = 1'b1; D = '0;
    #1;
    Reset = 1'b1;
    #11;
    test_reset();
    test_lsb_first();
    step();
    test_msb_first();
    step();
    test_backpressure();
    step();
    test_start_ignored();
    step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
